fpu_seq: RTL and testbench

- Multi-cycle FP responder serving the execution stage's FP request/valid handshake.
- The execution stage raises start with op/a/b held stable and waits for a one-cycle valid pulse carrying result.
- Implements an iterative single-precision multiply plus single-cycle sign, move and compare ops.
- Contains a post-completion rest cycle so a still-asserted stale request is never re-executed.

---
 rtl/fpu_seq.sv | 150 +++++++++++++++
 tb/tb_fpu_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
// Sequential FP responder: iterative single-precision multiply plus
// single-cycle sign, move and compare ops behind a start/valid handshake.
module fpu_seq #(
  parameter int MANT_W   = 24,
  parameter int EXP_BIAS = 127
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        valid
);

  localparam int FW = MANT_W - 1;
  localparam int PW = 2 * MANT_W;
  localparam int CW = $clog2(MANT_W);

  localparam logic [3:0] OP_FMUL = 4'h0;
  localparam logic [3:0] OP_FNEG = 4'h1;
  localparam logic [3:0] OP_FABS = 4'h2;
  localparam logic [3:0] OP_FEQ  = 4'h3;
  localparam logic [3:0] OP_FLT  = 4'h4;
  localparam logic [3:0] OP_FLE  = 4'h5;
  localparam logic [3:0] OP_FMOV = 4'h6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_DONE,
    S_REST
  } state_t;

  state_t          state;
  logic            sgn_q;
  logic [7:0]      ea_q;
  logic [7:0]      eb_q;
  logic [PW-1:0]   mcand;
  logic [MANT_W-1:0] mplier;
  logic [PW-1:0]   prod;
  logic [CW-1:0]   cnt;

  logic [31:0]     simple_res;
  logic [31:0]     mul_res;
  logic [9:0]      e_sum;
  logic [9:0]      e_adj;
  logic [FW-1:0]   frac_n;

  // Sign-magnitude ordering; both zeros compare equal regardless of sign.
  function automatic logic lt_sm(input logic [31:0] x, input logic [31:0] y);
    if (x[30:0] == '0 && y[30:0] == '0)
      lt_sm = 1'b0;
    else if (x[31] != y[31])
      lt_sm = x[31];
    else if (x[31])
      lt_sm = x[30:0] > y[30:0];
    else
      lt_sm = x[30:0] < y[30:0];
  endfunction

  function automatic logic eq_sm(input logic [31:0] x, input logic [31:0] y);
    eq_sm = (x == y) || (x[30:0] == '0 && y[30:0] == '0);
  endfunction

  always_comb begin
    simple_res = '0;
    case (op)
      OP_FNEG: simple_res = {~a[31], a[30:0]};
      OP_FABS: simple_res = {1'b0, a[30:0]};
      OP_FEQ:  simple_res = {31'b0, eq_sm(a, b)};
      OP_FLT:  simple_res = {31'b0, lt_sm(a, b)};
      OP_FLE:  simple_res = {31'b0, lt_sm(a, b) | eq_sm(a, b)};
      OP_FMOV: simple_res = a;
      default: simple_res = '0;
    endcase
  end

  // Normalise and pack; specials are resolved from the latched exponents.
  always_comb begin
    e_sum  = {2'b00, ea_q} + {2'b00, eb_q} - 10'(EXP_BIAS);
    e_adj  = prod[PW-1] ? e_sum + 10'd1 : e_sum;
    frac_n = prod[PW-1] ? prod[PW-2 -: FW] : prod[PW-3 -: FW];
    mul_res = {sgn_q, e_adj[7:0], frac_n};
    if (ea_q == 8'h00 || eb_q == 8'h00)
      mul_res = {sgn_q, 31'b0};
    else if (ea_q == 8'hFF || eb_q == 8'hFF)
      mul_res = {sgn_q, 8'hFF, 23'b0};
    else if ($signed(e_adj) >= 10'sd255)
      mul_res = {sgn_q, 8'hFF, 23'b0};
    else if ($signed(e_adj) <= 10'sd0)
      mul_res = {sgn_q, 31'b0};
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      valid  <= 1'b0;
      result <= '0;
      sgn_q  <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      valid <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            sgn_q  <= a[31] ^ b[31];
            ea_q   <= a[30:23];
            eb_q   <= b[30:23];
            mcand  <= PW'({1'b1, a[FW-1:0]});
            mplier <= {1'b1, b[FW-1:0]};
            prod   <= '0;
            cnt    <= '0;
            if (op == OP_FMUL) begin
              state <= S_MUL;
            end else begin
              result <= simple_res;
              state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          if (mplier[0])
            prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MANT_W - 1))
            state <= S_NORM;
        end
        S_NORM: begin
          result <= mul_res;
          state  <= S_DONE;
        end
        S_DONE: state <= S_REST;
        // The requester still holds its old start here; let it drop.
        S_REST: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed plus randomized checks of fpu_seq against a
// value-level reference model.
module tb_fpu_seq;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        valid;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  fpu_seq dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .result(result),
    .valid(valid)
  );

  // Signed integer key: sign-magnitude order, +0 and -0 both map to 0.
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'({1'b0, x[30:0]});
    key = x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int ea, eb, e;
    logic [63:0] p, f;
    s  = x[31] ^ y[31];
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    if (ea == 0 || eb == 0) return {s, 31'b0};
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'b0};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      e = e + 1;
      f = p >> 24;
    end else begin
      f = p >> 23;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0) return {s, 31'b0};
    return {s, 8'(e), f[22:0]};
  endfunction

  function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    case (o)
      4'h0: return ref_mul(x, y);
      4'h1: return {~x[31], x[30:0]};
      4'h2: return {1'b0, x[30:0]};
      4'h3: return {31'b0, key(x) == key(y)};
      4'h4: return {31'b0, key(x) < key(y)};
      4'h5: return {31'b0, key(x) <= key(y)};
      4'h6: return x;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request held for a single sampling edge and check it.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    int lat;
    logic seen;
    logic [31:0] res, exp;
    exp = ref_model(o, x, y);
    @(negedge CLK);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    seen = 1'b0;
    lat = -1;
    res = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (i == 0) start = 1'b0;
      if (valid) begin
        seen = 1'b1;
        lat = i;
        res = result;
      end
    end
    chk({tag, " lat"}, 32'(lat), (o == 4'h0) ? 32'd26 : 32'd1);
    chk({tag, " res"}, res, exp);
    @(posedge CLK);
    #1;
    chk({tag, " pulse"}, {31'b0, valid}, 32'd0);
  endtask

  // Hold start across `hold` sampling edges; count valid pulses.
  task automatic held_op(input string tag, input int hold, input int exp_n);
    int nv;
    logic [31:0] last;
    @(negedge CLK);
    op = 4'h1;
    a = 32'h3F800000;
    b = '0;
    start = 1'b1;
    nv = 0;
    last = '0;
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK);
      #1;
      if (i == hold - 1) start = 1'b0;
      if (valid) begin
        nv++;
        last = result;
      end
    end
    chk({tag, " count"}, 32'(nv), 32'(exp_n));
    chk({tag, " res"}, last, 32'hBF800000);
  endtask

  initial begin
    int nv;
    logic [3:0] o;
    logic [31:0] x, y;
    int r;

    #2 reset_n = 1'b0;
    #1;
    chk("rst valid", {31'b0, valid}, 32'd0);
    chk("rst result", result, 32'd0);
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;

    do_op("fmul 2x3", 4'h0, 32'h40000000, 32'h40400000);
    do_op("fmul 1.5sq", 4'h0, 32'h3FC00000, 32'h3FC00000);
    do_op("fmul ovf", 4'h0, 32'h7F000000, 32'h7F000000);
    do_op("fmul unf", 4'h0, 32'h00800000, 32'h00800000);
    do_op("fmul zero inf", 4'h0, 32'h80000000, 32'h7F800000);
    do_op("fmul inf", 4'h0, 32'h7F800000, 32'hC0000000);

    held_op("fneg hold3", 3, 1);
    held_op("fneg hold4", 4, 2);

    do_op("flt neg pos", 4'h4, 32'hBF800000, 32'h3F800000);
    do_op("feq zeros", 4'h3, 32'h80000000, 32'h00000000);
    do_op("fle negs", 4'h5, 32'hC0000000, 32'hBF800000);
    do_op("flt equal", 4'h4, 32'h40490FDB, 32'h40490FDB);
    do_op("fmov", 4'h6, 32'h12345678, 32'h0);
    do_op("illegal op", 4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF);

    do_op("b2b fmul", 4'h0, 32'h40000000, 32'h40400000);
    do_op("b2b fabs", 4'h2, 32'hC0A00000, 32'h0);

    do_op("pre-rst fmul", 4'h0, 32'h40000000, 32'h40400000);
    @(negedge CLK);
    op = 4'h0;
    a = 32'h40000000;
    b = 32'h40400000;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 reset_n = 1'b0;
    #1;
    chk("abort valid", {31'b0, valid}, 32'd0);
    chk("abort result", result, 32'd0);
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (valid) nv++;
    end
    chk("abort no valid", 32'(nv), 32'd0);
    do_op("post-rst fneg", 4'h1, 32'h3F800000, 32'h0);

    for (int k = 0; k < 40; k++) begin
      o = 4'($urandom_range(0, 8));
      x = $urandom;
      y = $urandom;
      r = $urandom_range(0, 4);
      if (r == 0) y = x;
      if (r == 1) begin
        x[30:0] = '0;
        y[30:0] = '0;
      end
      if (r == 2) y = {~x[31], x[30:0]};
      do_op($sformatf("rand%0d op%0h", k, o), o, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
